// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Owns the architectural PC and sequences instruction fetch for the
//   single-cycle core. A request/acknowledge handshake fetches one word into
//   the instruction register. The next PC is selected at retire, with
//   priority jump > branch > +4. The selection is shown on pc_src using the
//   PC mux encoding.
//   Optional feature macro: PC_MISALIGN_TRAP_EN. When it is defined, a
//   misaligned redirect target traps. When it is undefined, the low two
//   target bits are cleared on load.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [1:0]  pc_src,
  output logic        fetch_err,
  output logic        misalign_trap
);

  localparam int unsigned        CNT_W    = $clog2(FETCH_TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  localparam logic [1:0] SRC_PLUS4  = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_EXEC = 2'b01,
    S_ERR  = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_started;      // low until the first clock after reset release
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_instr_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fetch_err;

  logic             w_req;
  logic             w_ack_take;
  logic             w_timeout;
  logic             w_retire;
  logic [1:0]       w_pc_src;
  logic [31:0]      w_target;
  logic [31:0]      w_pc_plus4;

`ifdef PC_MISALIGN_TRAP_EN
  logic             r_misalign_trap;
  logic             w_misaligned;
`endif

  assign w_pc_plus4 = r_pc + 32'd4;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is assigned with <= so every flop samples
      // pre-edge values; blocking here would create order-dependent races.
      r_state <= S_REQ;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic, fetch handshake decode and retire target selection.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_req        = 1'b0;
    w_ack_take   = 1'b0;
    w_timeout    = 1'b0;
    w_retire     = 1'b0;
    w_pc_src     = SRC_PLUS4;
    w_target     = w_pc_plus4;
`ifdef PC_MISALIGN_TRAP_EN
    w_misaligned = 1'b0;
`endif
    unique case (r_state)
      S_REQ: begin
        // Request is held off for the first cycle after reset, so an ack
        // left over from before reset can never be taken.
        w_req = r_started;
        if (r_started) begin
          if (imem_ack) begin
            w_ack_take   = 1'b1;
            w_next_state = S_EXEC;
          end else if (r_cnt == CNT_LAST) begin
            w_timeout    = 1'b1;
            w_next_state = S_ERR;
          end
        end
      end
      S_EXEC: begin
        if (!stall) begin
          w_retire     = 1'b1;
          w_next_state = S_REQ;
          if (jump_valid) begin
            w_pc_src = SRC_JUMP;
            w_target = jump_target;
          end else if (branch_taken) begin
            w_pc_src = SRC_BRANCH;
            w_target = branch_target;
          end
`ifdef PC_MISALIGN_TRAP_EN
          if (w_target[1:0] != 2'b00) begin
            w_misaligned = 1'b1;
            w_next_state = S_ERR;
          end
`endif
        end
      end
      S_ERR: begin
        w_next_state = S_ERR;
      end
      default: begin
        w_next_state = S_REQ;
      end
    endcase
  end

  // PC, instruction register, timeout counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started     <= 1'b0;
      r_pc          <= RESET_VECTOR;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
      r_cnt         <= '0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (w_ack_take) begin
        r_instr       <= imem_rdata;
        r_instr_valid <= 1'b1;
        r_cnt         <= '0;
      end else if (w_req) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end
      if (w_retire) begin
        r_instr_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        if (!w_misaligned) begin
          r_pc <= w_target;
        end
`else
        r_pc <= w_target & ~32'd3;
`endif
      end
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign_trap <= 1'b0;
    end else if (w_retire && w_misaligned) begin
      r_misalign_trap <= 1'b1;
    end
  end
  assign misalign_trap = r_misalign_trap;
`else
  assign misalign_trap = 1'b0;
`endif

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign pc_src      = w_pc_src;
  assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer
//   Drives the fetch sequencer through reset, sequential flow, redirect
//   priority, stalls, PC wrap, misaligned targets and fetch timeout.
//   Expected fetch addresses are produced by a small PC model and queued at
//   retire. They are popped when the DUT raises imem_req.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int          TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  pc_src;
  logic        fetch_err;
  logic        misalign_trap;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;

  pc_fetch_sequencer #(.RESET_VECTOR(RV), .FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .pc_src(pc_src), .fetch_err(fetch_err), .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for a request, check its address against the scoreboard, then ack it.
  task automatic fetch(input logic [31:0] rdata, input int wait_cyc);
    logic [31:0] exp_addr;
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_req: imem_req=%b required 1 within 20 cycles", imem_req);
    end
    exp_addr = 32'hDEAD_BEEF;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL fetch_sb: request at %h with nothing expected", imem_addr);
    end else begin
      exp_addr = exp_q.pop_front();
      if (imem_addr !== exp_addr) begin
        errors++;
        $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, exp_addr);
      end
    end
    for (int i = 0; i < wait_cyc; i++) begin
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
        errors++;
        $display("FAIL fetch_hold: req=%b addr=%h required 1 %h", imem_req, imem_addr, exp_addr);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    step();
    imem_ack   = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== rdata || pc !== exp_addr || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done: valid=%b instr=%h pc=%h req=%b required 1 %h %h 0",
               instr_valid, instr, pc, imem_req, rdata, exp_addr);
    end
  endtask

  // Release stall for one cycle with the given redirects; model the next PC.
  task automatic retire(input logic jv, input logic [31:0] jt,
                        input logic bv, input logic [31:0] bt);
    logic [1:0]  exp_src;
    logic [31:0] exp_tgt;
    if (jv) begin
      exp_src = 2'b10; exp_tgt = jt;
    end else if (bv) begin
      exp_src = 2'b01; exp_tgt = bt;
    end else begin
      exp_src = 2'b00; exp_tgt = m_pc + 32'd4;
    end
    jump_valid = jv; jump_target = jt; branch_taken = bv; branch_target = bt;
    stall = 1'b0;
    #1;
    checks++;
    if (pc_src !== exp_src || pc_plus4 !== m_pc + 32'd4) begin
      errors++;
      $display("FAIL retire_src: pc_src=%b pc_plus4=%h required %b %h",
               pc_src, pc_plus4, exp_src, m_pc + 32'd4);
    end
    m_pc = exp_tgt & ~32'd3;
    exp_q.push_back(m_pc);
    step();
    stall = 1'b1; jump_valid = 1'b0; branch_taken = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || pc_src !== 2'b00) begin
      errors++;
      $display("FAIL retire_next: valid=%b req=%b src=%b required 0 1 00",
               instr_valid, imem_req, pc_src);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b1; jump_valid = 1'b0; branch_taken = 1'b0;
    jump_target = '0; branch_target = '0;
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    #12;
    checks++;
    if (pc !== RV || instr !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0 ||
        fetch_err !== 1'b0 || misalign_trap !== 1'b0 || pc_src !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: pc=%h instr=%h v=%b req=%b ferr=%b mis=%b src=%b required %h 0 all-zero",
               pc, instr, instr_valid, imem_req, fetch_err, misalign_trap, pc_src, RV);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_req: imem_req=%b required 0", imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RV || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_cycle1: req=%b addr=%h valid=%b required 1 %h 0",
               imem_req, imem_addr, instr_valid, RV);
    end
    step();
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0000_0013 || pc !== RV) begin
      errors++;
      $display("FAIL reset_cycle2: valid=%b instr=%h pc=%h required 1 00000013 %h",
               instr_valid, instr, pc, RV);
    end
    m_pc = RV;
  endtask

  task automatic test_sequential();
    retire(1'b1, 32'h0000_0100, 1'b0, 32'h0);
    fetch(32'hAAAA_0001, 0);
    retire(1'b0, 32'h0, 1'b0, 32'h0);
    fetch(32'hAAAA_0002, 3);
  endtask

  task automatic test_priority();
    retire(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300);
    fetch(32'hAAAA_0003, 0);
  endtask

  task automatic test_stall();
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    held_instr = instr;
    held_pc    = pc;
    branch_taken = 1'b1; branch_target = 32'h0000_0500;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (instr !== held_instr || pc !== held_pc || imem_req !== 1'b0 ||
          pc_src !== 2'b00 || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: instr=%h pc=%h req=%b src=%b v=%b required %h %h 0 00 1",
                 instr, pc, imem_req, pc_src, instr_valid, held_instr, held_pc);
      end
    end
    branch_taken = 1'b0;
    retire(1'b0, 32'h0, 1'b0, 32'h0);
    fetch(32'hAAAA_0004, 0);
    held_pc = pc;
    step();
    step();
    checks++;
    if (pc !== held_pc || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_single_retire: pc=%h req=%b v=%b required %h 0 1",
               pc, imem_req, instr_valid, held_pc);
    end
  endtask

  task automatic test_wrap();
    retire(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    fetch(32'hAAAA_0005, 0);
    checks++;
    if (pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_plus4: pc_plus4=%h required 00000000", pc_plus4);
    end
    retire(1'b0, 32'h0, 1'b0, 32'h0);
    fetch(32'hAAAA_0006, 1);
  endtask

  task automatic test_misalign();
`ifdef PC_MISALIGN_TRAP_EN
    logic [31:0] held_pc;
    held_pc = pc;
    branch_taken = 1'b1; branch_target = 32'h0000_0102; stall = 1'b0;
    #1;
    checks++;
    if (pc_src !== 2'b01) begin
      errors++;
      $display("FAIL misalign_src: pc_src=%b required 01", pc_src);
    end
    step();
    stall = 1'b1; branch_taken = 1'b0;
    checks++;
    if (misalign_trap !== 1'b1 || fetch_err !== 1'b0 || pc !== held_pc ||
        imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_trap: trap=%b ferr=%b pc=%h req=%b v=%b required 1 0 %h 0 0",
               misalign_trap, fetch_err, pc, imem_req, instr_valid, held_pc);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_pc = RV;
    exp_q.push_back(RV);
    fetch(32'hAAAA_0007, 0);
`else
    retire(1'b0, 32'h0, 1'b1, 32'h0000_0102);
    fetch(32'hAAAA_0007, 0);
    checks++;
    if (misalign_trap !== 1'b0) begin
      errors++;
      $display("FAIL misalign_tied: misalign_trap=%b required 0", misalign_trap);
    end
`endif
  endtask

  task automatic test_timeout();
    retire(1'b1, 32'h0000_0400, 1'b0, 32'h0);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL timeout_sb: nothing expected for request at %h", imem_addr);
    end else if (exp_q.pop_front() !== imem_addr) begin
      errors++;
      $display("FAIL timeout_addr: imem_addr=%h required 00000400", imem_addr);
    end
    for (int i = 0; i < TO; i++) begin
      checks++;
      if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait: cycle %0d req=%b ferr=%b required 1 0", i, imem_req, fetch_err);
      end
      step();
    end
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: ferr=%b req=%b v=%b required 1 0 0", fetch_err, imem_req, instr_valid);
    end
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ack = 1'b0;
    step();
    checks++;
    if (instr_valid !== 1'b0 || fetch_err !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0000_0400) begin
      errors++;
      $display("FAIL timeout_late_ack: v=%b ferr=%b req=%b pc=%h required 0 1 0 00000400",
               instr_valid, fetch_err, imem_req, pc);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== RV || fetch_err !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_reset: pc=%h ferr=%b req=%b required %h 0 0", pc, fetch_err, imem_req, RV);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected fetches never seen required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_priority();
    test_stall();
    test_wrap();
    test_misalign();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
